// File: rtl/rca_slice_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rca_slice_sequencer_pkg
//   Shared constants for the sliced ripple-carry add/subtract unit:
//   default datapath widths, FSM state encodings and a small helper for
//   sizing the slice index.
//   No ports (package).
// ---------------------------------------------------------------------------
package rca_slice_sequencer_pkg;

    // Default datapath geometry.
    localparam int WIDTH_DEF = 64;
    localparam int SLICE_DEF = 16;

    // FSM state encodings. Kept as plain 2-bit constants so that older
    // tools and checkers that match on raw encodings keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width needed to index n slices. Never returns less than 1, so a
    // single-slice configuration still has a legal index register.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : rca_slice_sequencer_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell, the building block of the ripple slice.
//   Ports:
//     a, b  : addend bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/rca_slice.sv
// ---------------------------------------------------------------------------
// rca_slice
//   Combinational W-bit ripple-carry adder made of a chain of full_adder
//   cells. This is the only carry chain in the unit, so its length (W) sets
//   the critical combinational path of the whole add/subtract sequencer.
//   Ports:
//     a, b      : W-bit addends
//     c0        : carry into bit 0
//     s         : W-bit sum
//     c         : carry out of bit W-1
//     c_msb_in  : carry into bit W-1 (used for signed overflow on the top
//                 slice: overflow = carry-in of MSB XOR carry-out of MSB)
// ---------------------------------------------------------------------------
module rca_slice
    import rca_slice_sequencer_pkg::*;
#(
    parameter int W = SLICE_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c0,
    output logic [W-1:0] s,
    output logic         c,
    output logic         c_msb_in
);

    // carry[i] is the carry into bit i; carry[W] leaves the slice.
    logic [W:0] carry;

    assign carry[0] = c0;

    for (genvar g = 0; g < W; g++) begin : g_bit
        full_adder u_fa (
            .a  (a[g]),
            .b  (b[g]),
            .ci (carry[g]),
            .s  (s[g]),
            .co (carry[g+1])
        );
    end

    assign c        = carry[W];
    assign c_msb_in = carry[W-1];

endmodule : rca_slice

// File: rtl/rca_slice_sequencer.sv
// ---------------------------------------------------------------------------
// rca_slice_sequencer
//   Multi-cycle WIDTH-bit add/subtract unit. One SLICE-bit ripple slice is
//   reused for NSLICE = WIDTH/SLICE cycles, LSB slice first, with the carry
//   between slices held in a register. This keeps the combinational carry
//   path at SLICE bits at the cost of NSLICE+1 cycles per operation.
//
//   Operation:
//     sub = 0 : s = a + b + c0
//     sub = 1 : s = a - b, computed as a + ~b + 1 (c0 ignored)
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : request a new operation (sampled only in IDLE or DONE)
//     sub    : 0 = add with carry-in, 1 = subtract
//     a, b   : WIDTH-bit operands, captured on the accepted start
//     c0     : carry-in, captured on the accepted start
//     busy   : high while slices are being processed
//     done   : one-cycle pulse when s/c/ovf are valid
//     s      : WIDTH-bit result, stable from done until the next accepted
//              start (intermediate values during busy are not meaningful)
//     c      : carry out of bit WIDTH-1 (for sub, 1 = no borrow)
//     ovf    : signed overflow (carry into MSB XOR carry out of MSB)
//
//   Handshake: start is a request qualified only by the FSM being in IDLE
//   or DONE; there is no ready output, so a start raised while busy is
//   simply dropped. done is a single-cycle valid for s/c/ovf with no
//   backpressure; a start in the DONE cycle is accepted back-to-back.
//
//   Timing: start accepted at edge 0; slices processed on edges 1..NSLICE;
//   done is high in the cycle following edge NSLICE.
// ---------------------------------------------------------------------------
module rca_slice_sequencer
    import rca_slice_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;

    // Index of the most significant slice; reaching it ends the RUN phase.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NSLICE - 1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]                    state;
    logic [SEL_W-1:0]              idx;

    // Operands and result are stored slice-major so the active slice is
    // selected with a plain index rather than a computed bit offset.
    logic [NSLICE-1:0][SLICE-1:0]  op_a;
    logic [NSLICE-1:0][SLICE-1:0]  op_b;
    logic [NSLICE-1:0][SLICE-1:0]  sum_q;

    logic                          cin;     // carry into the current slice
    logic                          c_q;
    logic                          ovf_q;

    // -----------------------------------------------------------------------
    // Shared slice adder
    // -----------------------------------------------------------------------
    logic [SLICE-1:0]              sl_s;
    logic                          sl_c;
    logic                          sl_c_msb_in;

    rca_slice #(
        .W (SLICE)
    ) u_slice (
        .a        (op_a[idx]),
        .b        (op_b[idx]),
        .c0       (cin),
        .s        (sl_s),
        .c        (sl_c),
        .c_msb_in (sl_c_msb_in)
    );

    // A new operation may only be taken when nothing is in flight.
    logic accept;
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // -----------------------------------------------------------------------
    // FSM + datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            sum_q <= '0;
            cin   <= 1'b0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        // Subtraction is folded into the operands here so
                        // the RUN phase is a pure add: a + ~b + 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        cin   <= sub ? 1'b1 : c0;
                        idx   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    sum_q[idx] <= sl_s;
                    cin        <= sl_c;
                    if (idx == LAST_IDX) begin
                        // Top slice: its carry-out is the result carry and
                        // its MSB carries give the signed overflow.
                        c_q   <= sl_c;
                        ovf_q <= sl_c_msb_in ^ sl_c;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + SEL_W'(1);
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean idle.
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // busy/done decode the state register directly, so both drop to 0 the
    // instant reset is asserted.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign s    = sum_q;
    assign c    = c_q;
    assign ovf  = ovf_q;

endmodule : rca_slice_sequencer

// File: tb/tb_rca_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rca_slice_sequencer
//   Self-checking bench for rca_slice_sequencer (default 64/16 geometry).
//   Expected results come from a whole-word arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rca_slice_sequencer;

    localparam int W = 64;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rca_slice_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c),
        .ovf   (ovf)
    );

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    // Expected results queued at issue time, popped at done.
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_flag_q[$];   // {ovf, c}

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: full-width arithmetic, one extra bit for the carry.
    // Signed overflow: both addends share a sign that the sum does not.
    task automatic model_push(input logic [W-1:0] ma, input logic [W-1:0] mb,
                              input logic mc0, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ci;
        logic         mo;
        bb   = msub ? ~mb : mb;
        ci   = msub ? 1'b1 : mc0;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        mo   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        exp_q.push_back(full[W-1:0]);
        exp_flag_q.push_back({mo, full[W]});
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks (all called and returning at a falling edge)
    // -----------------------------------------------------------------------
    // Waits for done, checking busy in every cycle before it. lat counts
    // rising edges after the accepting edge.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            check({tag, "_busy_run"}, W'(busy), W'(1));
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, W'(done), W'(1));
        check({tag, "_busy_done"}, W'(busy), W'(0));
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] es;
        logic [1:0]   ef;
        es = exp_q.pop_front();
        ef = exp_flag_q.pop_front();
        check({tag, "_s"},   s,      es);
        check({tag, "_c"},   W'(c),   W'(ef[0]));
        check({tag, "_ovf"}, W'(ovf), W'(ef[1]));
    endtask

    // Issue one op, optionally scramble inputs after capture, then check.
    task automatic do_op(input string tag, input logic [W-1:0] oa,
                         input logic [W-1:0] ob, input logic oc0,
                         input logic osub, input bit scramble,
                         output int lat);
        start = 1'b1; a = oa; b = ob; c0 = oc0; sub = osub;
        model_push(oa, ob, oc0, osub);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            c0  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
        end
        wait_done(tag, lat);
        check_result(tag);
    endtask

    // Watch n cycles for a spurious done / busy.
    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check({tag, "_quiet"}, W'(seen), W'(0));
    endtask

    // -----------------------------------------------------------------------
    // Directed + random sequence
    // -----------------------------------------------------------------------
    initial begin
        int lat;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_s",    s,        W'(0));
        check("rst_c",    W'(c),    W'(0));
        check("rst_ovf",  W'(ovf),  W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Carry ripples through every slice.
        do_op("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0, lat);
        check("carry_all_lat", W'(lat), W'(4));
        check("carry_all_s_const", s, 64'h0);
        @(negedge clk);

        // Signed overflow.
        do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, lat);
        check("sovf_s_const", s, 64'h8000_0000_0000_0000);
        check("sovf_ovf_const", W'(ovf), W'(1));
        @(negedge clk);

        // Subtract with borrow, then equal operands.
        do_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 1'b1, lat);
        check("sub_borrow_s_const", s, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_borrow_c_const", W'(c), W'(0));
        @(negedge clk);
        do_op("sub_eq", 64'h1234, 64'h1234, 1'b0, 1'b1, 1'b0, lat);
        check("sub_eq_s_const", s, 64'h0);
        check("sub_eq_c_const", W'(c), W'(1));
        @(negedge clk);

        // Start ignored while busy.
        start = 1'b1; a = 64'd1; b = 64'd2; c0 = 1'b0; sub = 1'b0;
        model_push(64'd1, 64'd2, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 64'd100;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ign_done_seen", W'(done), W'(1));
        check("ign_lat", W'(lat + 2), W'(4));
        check_result("ign");
        check("ign_s_const", s, 64'd3);
        expect_quiet("ign", 10);
        check("ign_s_hold", s, 64'd3);

        // Back-to-back: start in the DONE cycle.
        do_op("b2b_first", 64'd1000, 64'd24, 1'b0, 1'b0, 1'b0, lat);
        do_op("b2b_second", 64'd10, 64'd20, 1'b0, 1'b0, 1'b0, lat);
        check("b2b_gap", W'(lat + 1), W'(5));
        check("b2b_s_const", s, 64'd30);
        @(negedge clk);

        // Reset in the middle of RUN.
        start = 1'b1; a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h1111; c0 = 1'b1; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        check("mid_rst_s",    s,        W'(0));
        check("mid_rst_c",    W'(c),    W'(0));
        check("mid_rst_ovf",  W'(ovf),  W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("mid_rst", 8);
        do_op("post_rst", 64'd41, 64'd1, 1'b0, 1'b0, 1'b0, lat);
        check("post_rst_lat", W'(lat), W'(4));
        @(negedge clk);

        // Randomized operations with edge-biased operands, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                2: ra = {32'h0, $urandom};
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0: rb = 64'h0;
                1: rb = 64'h8000_0000_0000_0000;
                default: rb = {$urandom, $urandom};
            endcase
            do_op("rand", ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, lat);
            check("rand_lat", W'(lat), W'(4));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        check("exp_q_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rca_slice_sequencer
